arb_resp_router: RTL and testbench
==================================

Name: arb_resp_router

Overview:
- Return-path companion to the N-way priority request arbiter: the arbiter fans requests in, this block fans the matching responses back out.
- For every request the arbiter hands downstream, it records the winning port number in an in-order tag FIFO.
- Each single-stream response is then routed to the port at the FIFO head, through a one-deep registered output stage.
- Sits beside the arbiter between the N requesters and the shared downstream responder; downstream responses return in request order.

Parameters:
- N_PORTS, 5, number of requester ports (2..8).
- IDX_W, 6, width of the req_0_idx/response index payload.
- DEPTH, 4, maximum outstanding requests (tag FIFO entries, power of two, >=2).
- SRC_W, 3, width of port number; must satisfy 2**SRC_W >= N_PORTS.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset; assertion clears all state immediately.
- req_valid  in  1  arbiter out-handshake fired (io_out_valid & granted) this cycle.
- req_src  in  SRC_W  encoded index of the granted arbiter input.
- req_ready  out  1  tag FIFO can accept; ANDed into the arbiter's io_out_ready by the integrator.
- resp_in_valid  in  1  downstream response valid.
- resp_in_idx  in  IDX_W  response payload.
- resp_in_ready  out  1  response accepted this cycle.
- resp_out_valid  out  N_PORTS  one-hot per-port response valid.
- resp_out_ready  in  N_PORTS  per-port ready.
- resp_out_idx  out  IDX_W  payload, shared by all ports; qualified by resp_out_valid.
- outstanding  out  $clog2(DEPTH)+1  current tag FIFO occupancy.
- err  out  2  sticky flags: bit0 bad_src, bit1 orphan response.

Behaviour:
- Reset (async assert, sync deassert by integrator):
  - FIFO pointers and count cleared.
  - Holding register cleared: resp_out_valid = 0, resp_out_idx = 0.
  - err = 0, outstanding = 0.
  - Reset mid-operation discards all tags and any held response; no response is delivered afterwards.
- Tag FIFO:
  - req_ready = (count < DEPTH); the FIFO is never full-bypassed.
  - Enqueue on req_valid & req_ready & (req_src < N_PORTS).
  - req_valid & req_ready with req_src >= N_PORTS: handshake completes, nothing is enqueued, err[0] is set.
  - Pointers wrap modulo DEPTH.
  - Enqueue and dequeue in the same cycle: count unchanged, both take effect.
  - Enqueue when empty with a same-cycle response: the new tag is not usable until the next cycle (no bypass).
- Output stage (states IDLE/HOLD):
  - IDLE: resp_out_valid = 0. resp_in_ready = resp_in_valid-independent (!empty).
    - On resp_in_valid & !empty: load idx and head port, pop FIFO, go HOLD.
  - HOLD: resp_out_valid = one-hot(held_port). resp_in_ready = !empty & resp_out_ready[held_port].
    - Port ready and a new response accepted: reload and stay HOLD (back-to-back, full throughput).
    - Port ready and no new response: go IDLE.
    - Port not ready: hold; payload and valid stable.
- Latency: response accepted in cycle t appears on resp_out in cycle t+1.
- Orphan response (resp_in_valid while FIFO empty): not accepted (resp_in_ready = 0), err[1] set, stall continues until a tag arrives.
- err bits are cleared only by reset.
- outstanding counts FIFO entries only, not the held response.

Decomposition:
- Shared package arb_route_pkg: N_PORTS/IDX_W/SRC_W defaults, err bit position constants, and the out-state enum {IDLE, HOLD}.
- One natural sub-module: arb_tag_fifo, a parameterised DEPTH x SRC_W synchronous FIFO with count output and async active-low reset.
- The router instantiates arb_tag_fifo and holds only the output-stage FSM and error logic.

Test Plan:
- Reset then idle: after reset release, check resp_out_valid = 0, req_ready = 1, outstanding = 0, err = 0.
- In-order routing: enqueue src 2, 0, 4, then responses 0x11, 0x22, 0x33 with all ports ready → resp_out_valid = 5'b00100 with idx 0x11, then 5'b00001 with 0x22, then 5'b10000 with 0x33. Each appears one cycle after acceptance; outstanding returns to 0.
- Full and wrap: enqueue 4 tags → req_ready = 0. One response then lets one more enqueue in the following cycle. Repeat 10 requests to exercise pointer wrap; routing stays in order.
- Backpressure: tags {1,3}, responses {0x05, 0x06}, resp_out_ready[1] = 0 for 3 cycles → held 0x05 stays on port 1 and resp_in_ready = 0. After ready, 0x06 goes to port 3 on the next cycle.
- Errors: req_src = 6 with req_valid → handshake completes, outstanding unchanged, err = 2'b01. Response with FIFO empty → resp_in_ready = 0, err = 2'b11, both sticky.
- Reset mid-flight: 3 tags outstanding and HOLD active, assert reset for 1 cycle → outputs clear asynchronously, outstanding = 0, no further resp_out_valid after release.

Source files
------------

// File: rtl/arb_route_pkg.sv
// Shared types and defaults for the arbiter response router.
// Out-stage state enum, error bit positions and parameter defaults.
package arb_route_pkg;

    localparam int DEF_N_PORTS = 5;
    localparam int DEF_IDX_W   = 6;
    localparam int DEF_DEPTH   = 4;
    localparam int DEF_SRC_W   = 3;

    localparam int ERR_BAD_SRC = 0;
    localparam int ERR_ORPHAN  = 1;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } out_state_t;

endpackage

// File: rtl/arb_resp_router_if.sv
// Request-tag and response handshake bundle of the response router.
// slave = router side, master = arbiter/downstream/requester side.
interface arb_resp_router_if
    import arb_route_pkg::*;
#(
    parameter int N_PORTS = DEF_N_PORTS,
    parameter int IDX_W   = DEF_IDX_W,
    parameter int SRC_W   = DEF_SRC_W
);

    logic               req_valid;
    logic [SRC_W-1:0]   req_src;
    logic               req_ready;

    logic               resp_in_valid;
    logic [IDX_W-1:0]   resp_in_idx;
    logic               resp_in_ready;

    logic [N_PORTS-1:0] resp_out_valid;
    logic [N_PORTS-1:0] resp_out_ready;
    logic [IDX_W-1:0]   resp_out_idx;

    modport slave (
        input  req_valid,
        input  req_src,
        output req_ready,
        input  resp_in_valid,
        input  resp_in_idx,
        output resp_in_ready,
        output resp_out_valid,
        input  resp_out_ready,
        output resp_out_idx
    );

    modport master (
        output req_valid,
        output req_src,
        input  req_ready,
        output resp_in_valid,
        output resp_in_idx,
        input  resp_in_ready,
        input  resp_out_valid,
        output resp_out_ready,
        input  resp_out_idx
    );

endinterface

// File: rtl/arb_tag_fifo.sv
// In-order tag FIFO holding the winning port of each granted request.
// Head is read from storage only, so a fresh tag is never bypassed.
module arb_tag_fifo #(
    parameter int  DEPTH = 4,
    parameter int  W     = 3,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  dout,
    output logic [CW-1:0] count,
    output logic          empty
);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          full;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    // Storage, wrapping pointers and occupancy count.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + PW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/arb_resp_router.sv
// Routes in-order downstream responses back to the requesting port.
// Tag FIFO records winners; a one-deep hold stage drives the ports.
module arb_resp_router
    import arb_route_pkg::*;
#(
    parameter int  N_PORTS = DEF_N_PORTS,
    parameter int  IDX_W   = DEF_IDX_W,
    parameter int  DEPTH   = DEF_DEPTH,
    parameter int  SRC_W   = DEF_SRC_W,
    localparam int CNT_W   = $clog2(DEPTH) + 1
) (
    input  logic             clock,
    input  logic             reset,
    arb_resp_router_if.slave bus,
    output logic [CNT_W-1:0] outstanding,
    output logic [1:0]       err
);

    out_state_t         state_q;
    out_state_t         state_d;
    logic [SRC_W-1:0]   port_q;
    logic [IDX_W-1:0]   idx_q;
    logic [SRC_W-1:0]   head;
    logic [CNT_W-1:0]   count;
    logic               fifo_empty;
    logic               src_ok;
    logic               req_fire;
    logic               push;
    logic               accept;
    logic               out_fire;
    logic               in_ready;
    logic [N_PORTS-1:0] valid_oh;

    assign bus.req_ready      = (count < CNT_W'(DEPTH));
    assign req_fire           = bus.req_valid & bus.req_ready;
    assign src_ok             = ({1'b0, bus.req_src} < (SRC_W + 1)'(N_PORTS));
    assign push               = req_fire & src_ok;
    assign outstanding        = count;
    assign bus.resp_in_ready  = in_ready;
    assign bus.resp_out_valid = valid_oh;
    assign bus.resp_out_idx   = idx_q;

    arb_tag_fifo #(
        .DEPTH (DEPTH),
        .W     (SRC_W)
    ) u_tags (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .din   (bus.req_src),
        .pop   (accept),
        .dout  (head),
        .count (count),
        .empty (fifo_empty)
    );

    // Output-stage next state, port valids and response acceptance.
    always_comb begin
        state_d  = state_q;
        valid_oh = '0;
        in_ready = 1'b0;
        out_fire = 1'b0;
        unique case (state_q)
            IDLE: in_ready = ~fifo_empty;
            HOLD: begin
                valid_oh = N_PORTS'(1) << port_q;
                out_fire = |(valid_oh & bus.resp_out_ready);
                in_ready = ~fifo_empty & out_fire;
            end
            default: ;
        endcase
        accept = bus.resp_in_valid & in_ready;
        if (accept) state_d = HOLD;
        else if (out_fire) state_d = IDLE;
    end

    // Hold register: captures payload and head port on acceptance.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            port_q  <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                port_q <= head;
                idx_q  <= bus.resp_in_idx;
            end
        end
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            err <= '0;
        end else begin
            if (req_fire & ~src_ok) err[ERR_BAD_SRC] <= 1'b1;
            if (bus.resp_in_valid & fifo_empty) err[ERR_ORPHAN] <= 1'b1;
        end
    end

endmodule

// File: tb/tb_arb_resp_router.sv
// Directed bench for arb_resp_router: routing order, full/wrap,
// backpressure, sticky errors and mid-flight reset.
module tb_arb_resp_router;

    logic clock;
    logic reset;
    logic [2:0] outstanding;
    logic [1:0] err;
    int n_chk;
    int n_err;

    arb_resp_router_if #(.N_PORTS(5), .IDX_W(6), .SRC_W(3)) bus ();

    arb_resp_router #(
        .N_PORTS (5),
        .IDX_W   (6),
        .DEPTH   (4),
        .SRC_W   (3)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .bus         (bus.slave),
        .outstanding (outstanding),
        .err         (err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic enq(input logic [2:0] src);
        bus.req_valid = 1'b1;
        bus.req_src   = src;
        tick();
        bus.req_valid = 1'b0;
    endtask

    logic [2:0] q[$];
    int         sent;
    logic       pv;
    logic [2:0] pp;
    logic [5:0] pi;
    logic       exp_rr;
    logic       exp_ir;

    initial begin
        n_chk = 0;
        n_err = 0;
        reset = 1'b0;
        bus.req_valid      = 1'b0;
        bus.req_src        = '0;
        bus.resp_in_valid  = 1'b0;
        bus.resp_in_idx    = '0;
        bus.resp_out_ready = 5'b11111;
        tick();
        tick();
        reset = 1'b1;
        tick();

        chk("rst_valid", 32'(bus.resp_out_valid), 32'h0);
        chk("rst_req_ready", 32'(bus.req_ready), 32'h1);
        chk("rst_outstanding", 32'(outstanding), 32'h0);
        chk("rst_err", 32'(err), 32'h0);

        // in-order routing
        enq(3'd2);
        enq(3'd0);
        enq(3'd4);
        chk("ord_outstanding3", 32'(outstanding), 32'h3);
        bus.resp_in_valid = 1'b1;
        bus.resp_in_idx   = 6'h11;
        #1;
        chk("ord_in_ready", 32'(bus.resp_in_ready), 32'h1);
        tick();
        chk("ord_v0", 32'(bus.resp_out_valid), 32'b00100);
        chk("ord_i0", 32'(bus.resp_out_idx), 32'h11);
        bus.resp_in_idx = 6'h22;
        tick();
        chk("ord_v1", 32'(bus.resp_out_valid), 32'b00001);
        chk("ord_i1", 32'(bus.resp_out_idx), 32'h22);
        bus.resp_in_idx = 6'h33;
        tick();
        bus.resp_in_valid = 1'b0;
        chk("ord_v2", 32'(bus.resp_out_valid), 32'b10000);
        chk("ord_i2", 32'(bus.resp_out_idx), 32'h33);
        chk("ord_outstanding0", 32'(outstanding), 32'h0);
        tick();
        chk("ord_idle", 32'(bus.resp_out_valid), 32'h0);

        // full and wrap
        enq(3'd0);
        enq(3'd1);
        enq(3'd2);
        enq(3'd3);
        chk("full_req_ready", 32'(bus.req_ready), 32'h0);
        chk("full_outstanding", 32'(outstanding), 32'h4);
        bus.req_valid = 1'b1;
        bus.req_src   = 3'd4;
        tick();
        chk("full_blocked", 32'(outstanding), 32'h4);
        bus.resp_in_valid = 1'b1;
        bus.resp_in_idx   = 6'h15;
        #1;
        chk("full_in_ready", 32'(bus.resp_in_ready), 32'h1);
        tick();
        bus.resp_in_valid = 1'b0;
        #1;
        chk("full_req_ready_again", 32'(bus.req_ready), 32'h1);
        chk("full_outstanding3", 32'(outstanding), 32'h3);
        chk("full_v", 32'(bus.resp_out_valid), 32'b00001);
        chk("full_i", 32'(bus.resp_out_idx), 32'h15);
        tick();
        bus.req_valid = 1'b0;
        chk("full_refill", 32'(outstanding), 32'h4);
        chk("full_idle", 32'(bus.resp_out_valid), 32'h0);

        q = '{3'd1, 3'd2, 3'd3, 3'd4};
        sent = 0;
        pv = 1'b0;
        pp = '0;
        pi = '0;
        for (int c = 0; c < 40 && (sent < 10 || q.size() > 0); c++) begin
            bus.req_valid     = (sent < 10);
            bus.req_src       = 3'(sent % 5);
            bus.resp_in_valid = (q.size() > 0);
            bus.resp_in_idx   = 6'(c + 32);
            #1;
            exp_rr = (q.size() < 4);
            exp_ir = (q.size() > 0);
            chk("wrap_req_ready", 32'(bus.req_ready), 32'(exp_rr));
            chk("wrap_in_ready", 32'(bus.resp_in_ready), 32'(exp_ir));
            chk("wrap_valid", 32'(bus.resp_out_valid),
                pv ? (32'h1 << pp) : 32'h0);
            if (pv) chk("wrap_idx", 32'(bus.resp_out_idx), 32'(pi));
            pv = exp_ir;
            if (exp_ir) begin
                pp = q.pop_front();
                pi = bus.resp_in_idx;
            end
            if (bus.req_valid && exp_rr) begin
                q.push_back(bus.req_src);
                sent++;
            end
            tick();
        end
        bus.req_valid     = 1'b0;
        bus.resp_in_valid = 1'b0;
        chk("wrap_done", 32'(sent == 10 && q.size() == 0), 32'h1);
        chk("wrap_last_valid", 32'(bus.resp_out_valid),
            pv ? (32'h1 << pp) : 32'h0);
        chk("wrap_last_idx", 32'(bus.resp_out_idx), 32'(pi));
        tick();
        chk("wrap_idle", 32'(bus.resp_out_valid), 32'h0);
        chk("wrap_outstanding", 32'(outstanding), 32'h0);

        // backpressure
        enq(3'd1);
        enq(3'd3);
        bus.resp_out_ready = 5'b11101;
        bus.resp_in_valid  = 1'b1;
        bus.resp_in_idx    = 6'h05;
        tick();
        bus.resp_in_idx = 6'h06;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_valid", 32'(bus.resp_out_valid), 32'b00010);
            chk("bp_idx", 32'(bus.resp_out_idx), 32'h05);
            chk("bp_in_ready", 32'(bus.resp_in_ready), 32'h0);
            tick();
        end
        bus.resp_out_ready = 5'b11111;
        #1;
        chk("bp_release", 32'(bus.resp_in_ready), 32'h1);
        tick();
        bus.resp_in_valid = 1'b0;
        chk("bp_next_valid", 32'(bus.resp_out_valid), 32'b01000);
        chk("bp_next_idx", 32'(bus.resp_out_idx), 32'h06);
        tick();
        chk("bp_idle", 32'(bus.resp_out_valid), 32'h0);
        chk("bp_outstanding", 32'(outstanding), 32'h0);

        // errors
        bus.req_valid = 1'b1;
        bus.req_src   = 3'd6;
        #1;
        chk("bad_req_ready", 32'(bus.req_ready), 32'h1);
        tick();
        bus.req_valid = 1'b0;
        chk("bad_outstanding", 32'(outstanding), 32'h0);
        chk("bad_err", 32'(err), 32'b01);
        bus.resp_in_valid = 1'b1;
        bus.resp_in_idx   = 6'h01;
        #1;
        chk("orph_in_ready", 32'(bus.resp_in_ready), 32'h0);
        tick();
        chk("orph_err", 32'(err), 32'b11);
        chk("orph_valid", 32'(bus.resp_out_valid), 32'h0);
        bus.req_valid = 1'b1;
        bus.req_src   = 3'd2;
        #1;
        chk("orph_no_bypass", 32'(bus.resp_in_ready), 32'h0);
        tick();
        bus.req_valid = 1'b0;
        #1;
        chk("orph_tag_ready", 32'(bus.resp_in_ready), 32'h1);
        tick();
        bus.resp_in_valid = 1'b0;
        chk("orph_valid_late", 32'(bus.resp_out_valid), 32'b00100);
        chk("orph_idx_late", 32'(bus.resp_out_idx), 32'h01);
        tick();
        chk("err_sticky", 32'(err), 32'b11);

        // reset mid-flight
        enq(3'd0);
        enq(3'd1);
        enq(3'd2);
        enq(3'd3);
        bus.resp_out_ready = 5'b11110;
        bus.resp_in_valid  = 1'b1;
        bus.resp_in_idx    = 6'h2A;
        tick();
        bus.resp_in_valid = 1'b0;
        chk("mid_outstanding", 32'(outstanding), 32'h3);
        chk("mid_hold", 32'(bus.resp_out_valid), 32'b00001);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(bus.resp_out_valid), 32'h0);
        chk("mid_rst_idx", 32'(bus.resp_out_idx), 32'h0);
        chk("mid_rst_outstanding", 32'(outstanding), 32'h0);
        chk("mid_rst_err", 32'(err), 32'h0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        bus.resp_out_ready = 5'b11111;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("post_rst_valid", 32'(bus.resp_out_valid), 32'h0);
        end
        chk("post_rst_outstanding", 32'(outstanding), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
